// File: rtl/kd_tree_pkg.sv
// kd_tree_pkg: shared types and helpers for the KD-tree traversal pipeline.
//   node_t        : node word layout {median, dim}, median in the MSBs (default widths)
//   ctrl_state_e  : controller states (LOAD, RUN)
//   node_count()  : internal nodes in a tree of given depth (2**depth-1)
//   level_base()  : breadth-first index of the first node on a level (2**l-1)
package kd_tree_pkg;

    localparam int KD_DATA_WIDTH = 11;
    localparam int KD_K          = 5;
    localparam int KD_DEPTH      = 8;
    localparam int KD_TAG_WIDTH  = 8;
    localparam int KD_DIM_WIDTH  = $clog2(KD_K);

    typedef struct packed {
        logic [KD_DATA_WIDTH-1:0] median;
        logic [KD_DIM_WIDTH-1:0]  dim;
    } node_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    function automatic int node_count(input int depth);
        return (1 << depth) - 1;
    endfunction

    function automatic int level_base(input int level);
        return (1 << level) - 1;
    endfunction

endpackage

// File: rtl/kd_tree_stage.sv
// kd_tree_stage: one tree level of the traversal pipeline.
// Holds the 2**LEVEL nodes of its level, registers the incoming entry
// (valid, patch, tag, path prefix) and compares the registered patch against
// the node addressed by the prefix, producing the extended prefix.
// Compare is unsigned unless KD_TREE_SIGNED_EN is defined (two's complement).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   stall                   freeze the stage register
//   wr_en, wr_pos           node write strobe and position within this level
//   wr_median, wr_dim       node contents
//   valid_i/patch_i/tag_i/prefix_i  entry from the previous level
//   valid_o/patch_o/tag_o   registered entry
//   prefix_o                registered prefix with this level's decision bit set
module kd_tree_stage
    import kd_tree_pkg::*;
#(
    parameter int DATA_WIDTH = KD_DATA_WIDTH,
    parameter int K          = KD_K,
    parameter int DIM_WIDTH  = KD_DIM_WIDTH,
    parameter int TAG_WIDTH  = KD_TAG_WIDTH,
    parameter int DEPTH      = KD_DEPTH,
    parameter int LEVEL      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    wr_en,
    input  logic [DEPTH-1:0]        wr_pos,
    input  logic [DATA_WIDTH-1:0]   wr_median,
    input  logic [DIM_WIDTH-1:0]    wr_dim,
    input  logic                    valid_i,
    input  logic [K*DATA_WIDTH-1:0] patch_i,
    input  logic [TAG_WIDTH-1:0]    tag_i,
    input  logic [DEPTH-1:0]        prefix_i,
    output logic                    valid_o,
    output logic [K*DATA_WIDTH-1:0] patch_o,
    output logic [TAG_WIDTH-1:0]    tag_o,
    output logic [DEPTH-1:0]        prefix_o
);

    localparam int NODES   = 1 << LEVEL;
    // The prefix is kept MSB-aligned in a DEPTH-bit field: level l owns bit
    // DEPTH-1-l, so the node index on this level is the top LEVEL bits.
    localparam int SHIFT   = DEPTH - LEVEL;
    localparam int BIT_POS = DEPTH - 1 - LEVEL;

    logic [DATA_WIDTH-1:0]   median_mem [NODES];
    logic [DIM_WIDTH-1:0]    dim_mem    [NODES];

    logic                    valid_q;
    logic [K*DATA_WIDTH-1:0] patch_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [DEPTH-1:0]        prefix_q;

    logic [DATA_WIDTH-1:0]   median_sel;
    logic [DIM_WIDTH-1:0]    dim_sel;
    logic [DATA_WIDTH-1:0]   comp;
    logic                    go_right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NODES; n++) begin
                median_mem[n] <= '0;
                dim_mem[n]    <= '0;
            end
        end else if (wr_en) begin
            for (int n = 0; n < NODES; n++) begin
                if (wr_pos == DEPTH'(n)) begin
                    median_mem[n] <= wr_median;
                    dim_mem[n]    <= wr_dim;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            patch_q  <= '0;
            tag_q    <= '0;
            prefix_q <= '0;
        end else if (!stall) begin
            valid_q  <= valid_i;
            patch_q  <= patch_i;
            tag_q    <= tag_i;
            prefix_q <= prefix_i;
        end
    end

    always_comb begin
        median_sel = median_mem[0];
        dim_sel    = dim_mem[0];
        for (int n = 1; n < NODES; n++) begin
            if ((prefix_q >> SHIFT) == DEPTH'(n)) begin
                median_sel = median_mem[n];
                dim_sel    = dim_mem[n];
            end
        end
        // Out-of-range split dimensions fall back to component 0.
        comp = patch_q[DATA_WIDTH-1:0];
        for (int c = 1; c < K; c++) begin
            if (int'(dim_sel) == c) begin
                comp = patch_q[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef KD_TREE_SIGNED_EN
    assign go_right = $signed(comp) >= $signed(median_sel);
`else
    assign go_right = comp >= median_sel;
`endif

    assign valid_o  = valid_q;
    assign patch_o  = patch_q;
    assign tag_o    = tag_q;
    assign prefix_o = prefix_q | (DEPTH'(go_right) << BIT_POS);

endmodule

// File: rtl/kd_tree_traverse_pipe.sv
// kd_tree_traverse_pipe: pipelined KD-tree traversal, one query patch per cycle
// turned into a DEPTH-bit leaf index (first decision in the MSB).
// Nodes are loaded breadth-first through wr_valid/wr_data while in LOAD;
// queries are accepted only in RUN. Results emerge DEPTH cycles after
// acceptance; out_valid && !out_ready freezes the whole pipeline.
// Optional build macro: KD_TREE_SIGNED_EN (signed median compare).
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wr_valid, wr_data           node write {median, dim}
//   reload                      restart loading (ignored in RUN while busy)
//   loaded, load_done           RUN state flag, pulse when last node written
//   in_valid/in_ready, in_patch, in_tag     query handshake
//   out_valid/out_ready, out_leaf, out_tag  result handshake
//   busy                        some stage holds a valid entry
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_LOAD | accepting node writes at wcnt; queries blocked
// ST_RUN  | all nodes written; queries flow; node writes ignored
module kd_tree_traverse_pipe
    import kd_tree_pkg::*;
#(
    parameter int DATA_WIDTH = KD_DATA_WIDTH,
    parameter int K          = KD_K,
    parameter int DEPTH      = KD_DEPTH,
    parameter int TAG_WIDTH  = KD_TAG_WIDTH,
    parameter int DIM_WIDTH  = $clog2(K)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    input  logic [DATA_WIDTH+DIM_WIDTH-1:0] wr_data,
    input  logic                          reload,
    output logic                          loaded,
    output logic                          load_done,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [K*DATA_WIDTH-1:0]       in_patch,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DEPTH-1:0]              out_leaf,
    output logic [TAG_WIDTH-1:0]          out_tag,
    output logic                          busy
);

    localparam int               NODES     = node_count(DEPTH);
    localparam logic [DEPTH-1:0] LAST_NODE = DEPTH'(NODES - 1);

    ctrl_state_e             state_q, state_d;
    logic [DEPTH-1:0]        wcnt_q, wcnt_d;
    logic                    load_done_q, load_done_d;
    logic                    wr_fire;
    logic                    stall;

    logic [DATA_WIDTH-1:0]   wr_median;
    logic [DIM_WIDTH-1:0]    wr_dim;

    // Index l is the entry entering level l; index DEPTH is the output stage.
    logic [DEPTH:0]          valid_c;
    logic [K*DATA_WIDTH-1:0] patch_c  [DEPTH+1];
    logic [TAG_WIDTH-1:0]    tag_c    [DEPTH+1];
    logic [DEPTH-1:0]        prefix_c [DEPTH+1];
    // The last level's copy of the patch has no consumer.
    logic [K*DATA_WIDTH-1:0] patch_last_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            wcnt_q      <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        load_done_d = 1'b0;
        wr_fire     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (reload) begin
                    wcnt_d = '0;
                end else if (wr_valid) begin
                    wr_fire = 1'b1;
                    if (wcnt_q == LAST_NODE) begin
                        state_d     = ST_RUN;
                        wcnt_d      = '0;
                        load_done_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (reload && !busy) begin
                    state_d = ST_LOAD;
                    wcnt_d  = '0;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign wr_median = wr_data[DATA_WIDTH+DIM_WIDTH-1:DIM_WIDTH];
    assign wr_dim    = wr_data[DIM_WIDTH-1:0];

    assign loaded    = (state_q == ST_RUN);
    assign load_done = load_done_q;
    assign out_valid = valid_c[DEPTH];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = loaded && !stall;
    assign busy      = |valid_c[DEPTH:1];

    assign valid_c[0]  = in_valid && in_ready;
    assign patch_c[0]  = in_patch;
    assign tag_c[0]    = in_tag;
    assign prefix_c[0] = '0;

    for (genvar l = 0; l < DEPTH; l++) begin : g_level
        localparam int BASE = level_base(l);
        logic [DEPTH-1:0] wr_pos;
        logic             wr_en;

        // wcnt below this level's base wraps to a large value, so a single
        // unsigned bound selects exactly the nodes of this level.
        assign wr_pos = wcnt_q - DEPTH'(BASE);
        assign wr_en  = wr_fire && (wr_pos < DEPTH'(1 << l));

        kd_tree_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .K          (K),
            .DIM_WIDTH  (DIM_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH),
            .DEPTH      (DEPTH),
            .LEVEL      (l)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .stall     (stall),
            .wr_en     (wr_en),
            .wr_pos    (wr_pos),
            .wr_median (wr_median),
            .wr_dim    (wr_dim),
            .valid_i   (valid_c[l]),
            .patch_i   (patch_c[l]),
            .tag_i     (tag_c[l]),
            .prefix_i  (prefix_c[l]),
            .valid_o   (valid_c[l+1]),
            .patch_o   (patch_c[l+1]),
            .tag_o     (tag_c[l+1]),
            .prefix_o  (prefix_c[l+1])
        );
    end

    assign patch_last_unused = patch_c[DEPTH];

    // Masked so an idle output reads 0 regardless of stale stage contents.
    assign out_leaf = out_valid ? prefix_c[DEPTH] : '0;
    assign out_tag  = tag_c[DEPTH];

endmodule

// File: tb/tb_kd_tree_traverse_pipe.sv
module tb_kd_tree_traverse_pipe;

    localparam int DW    = 8;
    localparam int K     = 2;
    localparam int DEPTH = 3;
    localparam int TW    = 8;
    localparam int DIMW  = 2;
    localparam int NODES = 7;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                wr_valid = 1'b0;
    logic [DW+DIMW-1:0]  wr_data = '0;
    logic                reload = 1'b0;
    logic                loaded, load_done;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [K*DW-1:0]     in_patch = '0;
    logic [TW-1:0]       in_tag = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [DEPTH-1:0]    out_leaf;
    logic [TW-1:0]       out_tag;
    logic                busy;

    always #5 clk = ~clk;

    kd_tree_traverse_pipe #(
        .DATA_WIDTH (DW), .K (K), .DEPTH (DEPTH), .TAG_WIDTH (TW), .DIM_WIDTH (DIMW)
    ) dut (
        .clk (clk), .rst_n (rst_n), .wr_valid (wr_valid), .wr_data (wr_data),
        .reload (reload), .loaded (loaded), .load_done (load_done),
        .in_valid (in_valid), .in_ready (in_ready), .in_patch (in_patch), .in_tag (in_tag),
        .out_valid (out_valid), .out_ready (out_ready), .out_leaf (out_leaf),
        .out_tag (out_tag), .busy (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    int ld_pulses = 0;
    int cyc = 0;

    typedef struct packed {
        logic [TW-1:0]    tag;
        logic [DEPTH-1:0] leaf;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [DW-1:0]    c0;
        logic [DW-1:0]    c1;
        logic [TW-1:0]    tag;
        logic [DEPTH-1:0] leaf;
    } vec_t;
    vec_t vecs[8];

    logic [DW-1:0]   m_med [NODES];
    logic [DIMW-1:0] m_dim [NODES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic ge(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef KD_TREE_SIGNED_EN
        return $signed(a) >= $signed(b);
`else
        return a >= b;
`endif
    endfunction

    function automatic logic [DEPTH-1:0] model_leaf(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
        int p;
        int idx;
        logic [DW-1:0] c;
        p = 0;
        for (int l = 0; l < DEPTH; l++) begin
            idx = (1 << l) - 1 + p;
            c = (m_dim[idx] == 2'd1) ? c1 : c0;
            p = p * 2 + (ge(c, m_med[idx]) ? 1 : 0);
        end
        return p[DEPTH-1:0];
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (load_done) ld_pulses++;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected result: got tag 0x%0h leaf %0d, expected no result", out_tag, out_leaf);
            end else begin
                e = sb_q.pop_front();
                check("result tag", 32'(out_tag), 32'(e.tag));
                check("result leaf", 32'(out_leaf), 32'(e.leaf));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic write_node(input logic [DW-1:0] med, input logic [DIMW-1:0] dim);
        wr_valid = 1'b1;
        wr_data  = {med, dim};
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic load_from_model();
        ld_pulses = 0;
        for (int i = 0; i < NODES; i++) begin
            if (i == NODES - 1) check("load_done before last write", 32'(load_done), 0);
            write_node(m_med[i], m_dim[i]);
        end
        check("load_done after last write", 32'(load_done), 1);
        check("loaded after last write", 32'(loaded), 1);
        check("in_ready after load", 32'(in_ready), 1);
    endtask

    task automatic send(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                        input logic [TW-1:0] tag, input logic [DEPTH-1:0] exp_leaf);
        int waited;
        exp_t e;
        waited = 0;
        in_valid = 1'b1;
        in_patch = {c1, c0};
        in_tag   = tag;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL send timeout: in_ready stayed 0, expected 1 (tag 0x%0h)", tag);
                break;
            end
        end
        if (in_ready) begin
            e.tag  = tag;
            e.leaf = exp_leaf;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain complete", 32'(busy === 1'b0 && sb_q.size() == 0), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, c_start, out_start;

        vecs[0] = '{8'd80,  8'd60,  8'h11, 3'b111};
        vecs[1] = '{8'd0,   8'd0,   8'h22, 3'b000};
        vecs[2] = '{8'd30,  8'd49,  8'h33, 3'b011};
        vecs[3] = '{8'd69,  8'd50,  8'h44, 3'b101};
        vecs[4] = '{8'd255, 8'd9,   8'h55, 3'b010};
        vecs[5] = '{8'd5,   8'd20,  8'h66, 3'b001};
        vecs[6] = '{8'd40,  8'd5,   8'h77, 3'b010};
        vecs[7] = '{8'd10,  8'd200, 8'h88, 3'b101};

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset loaded", 32'(loaded), 0);
        check("reset load_done", 32'(load_done), 0);
        check("reset out_valid", 32'(out_valid), 0);
        check("reset busy", 32'(busy), 0);
        check("reset in_ready", 32'(in_ready), 0);
        check("reset out_leaf", 32'(out_leaf), 0);
        check("reset out_tag", 32'(out_tag), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready while loading", 32'(in_ready), 0);

        // load all {100, dim 0}; extra write in RUN must be ignored
        for (int i = 0; i < NODES; i++) begin m_med[i] = 8'd100; m_dim[i] = 2'd0; end
        load_from_model();
        write_node(8'd255, 2'd0);
        check("load_done single pulse", 32'(ld_pulses), 1);
        check("loaded after extra write", 32'(loaded), 1);
        send(8'd100, 8'd0, 8'h01, 3'b111);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 10);
        check("latency", 32'(n), DEPTH);
        @(posedge clk); #1;
        send(8'd99, 8'd255, 8'h02, 3'b000);
        drain();

        // reload and load the traversal tree
        reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
        check("loaded after idle reload", 32'(loaded), 0);
        m_med[0] = 8'd50; m_dim[0] = 2'd1;
        m_med[1] = 8'd30; m_dim[1] = 2'd0;
        m_med[2] = 8'd70; m_dim[2] = 2'd0;
        for (int i = 3; i < NODES; i++) begin m_med[i] = 8'd10; m_dim[i] = 2'd1; end
        load_from_model();

        c_start = cyc;
        for (int i = 0; i < 8; i++) send(vecs[i].c0, vecs[i].c1, vecs[i].tag, vecs[i].leaf);
        check("throughput cycles for 8", 32'(cyc - c_start), 8);
        drain();

        // back-pressure: 6 patches, out_ready low for 4 cycles
        out_start = n_out;
        fork
            begin
                logic [DW-1:0] a, b;
                for (int i = 0; i < 6; i++) begin
                    a = 8'($urandom_range(255));
                    b = 8'($urandom_range(255));
                    send(a, b, TW'(i), model_leaf(a, b));
                end
            end
            begin
                int w;
                w = 0;
                while (!out_valid && w < 20) begin @(negedge clk); w++; end
                check("first result before stall", 32'(out_valid), 1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("out_valid during stall", 32'(out_valid), 1);
                    check("in_ready during stall", 32'(in_ready), 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("results after stall", 32'(n_out - out_start), 6);

        // reload while busy is ignored; idle reload returns to LOAD
        send(8'd50, 8'd50, 8'hC1, model_leaf(8'd50, 8'd50));
        check("busy after send", 32'(busy), 1);
        reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
        check("reload ignored while busy", 32'(loaded), 1);
        drain();
        reload = 1'b1; @(posedge clk); #1; reload = 1'b0;
        check("loaded after reload", 32'(loaded), 0);
        check("in_ready after reload", 32'(in_ready), 0);
        for (int i = 0; i < NODES; i++) begin m_med[i] = 8'd100; m_dim[i] = 2'd3; end
        load_from_model();
        send(8'd100, 8'd0, 8'hD1, 3'b111);
        send(8'd99, 8'd200, 8'hD2, 3'b000);
        drain();

        // async reset with two entries in flight
        send(8'd80, 8'd60, 8'hE1, model_leaf(8'd80, 8'd60));
        send(8'd0, 8'd0, 8'hE2, model_leaf(8'd0, 8'd0));
        #2 rst_n = 1'b0;
        #1;
        check("mid reset out_valid", 32'(out_valid), 0);
        check("mid reset loaded", 32'(loaded), 0);
        check("mid reset busy", 32'(busy), 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // sign handling: 0xF0 against median 0x10
        for (int i = 0; i < NODES; i++) begin m_med[i] = 8'h10; m_dim[i] = 2'd0; end
        load_from_model();
`ifdef KD_TREE_SIGNED_EN
        send(8'hF0, 8'h00, 8'hF1, 3'b000);
`else
        send(8'hF0, 8'h00, 8'hF1, 3'b111);
`endif
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
